// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/STAT registers on the CPU data bus,
// 16x-oversampled receiver with glitch rejection and a level interrupt.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          DIV16     = 65
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW = (DIV16 > 1) ? $clog2(DIV16) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    logic [29:0] base_word;
    logic        sel_txd, sel_rxd, sel_stat;
    logic        rd_rxd, rd_stat, wr_txd, wr_stat;
    logic        unused_bits;

    state_t      tx_state_q, tx_state_d;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_line_q, tx_line_d;

    logic        rx_meta_q, rx_s_q;
    state_t      rx_state_q, rx_state_d;
    logic [3:0]  rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_over_q, rx_over_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_armed_q, rx_armed_d;

    logic        rx_ie_q, rx_ie_d;
    logic        tx_ie_q, tx_ie_d;
    logic        irq_q, irq_d;

    assign tick       = (tick_cnt_q == CW'(DIV16 - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

    // Byte lanes are irrelevant: every register is a full word.
    assign base_word   = BASE_ADDR[31:2];
    assign sel_txd     = (addr[31:2] == base_word);
    assign sel_rxd     = (addr[31:2] == base_word + 30'd1);
    assign sel_stat    = (addr[31:2] == base_word + 30'd2);
    assign rd_rxd      = rd & sel_rxd;
    assign rd_stat     = rd & sel_stat;
    assign wr_txd      = wr & sel_txd;
    assign wr_stat     = wr & sel_stat;
    assign unused_bits = ^{addr[1:0], wdata[31:10]};

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)
                rdata = {24'b0, tx_data_q};
            else if (sel_rxd)
                rdata = {24'b0, rx_data_q};
            else if (sel_stat)
                rdata = {22'b0, tx_ie_q, rx_ie_q, 3'b0, frame_err_q, rx_over_q,
                         tx_done_q, tx_busy_q, rx_valid_q};
        end
    end

    always_comb begin
        rx_ie_d = rx_ie_q;
        tx_ie_d = tx_ie_q;
        if (wr_stat) begin
            rx_ie_d = wdata[8];
            tx_ie_d = wdata[9];
        end
        irq_d = (rx_valid_q & rx_ie_q) | (tx_done_q & tx_ie_q);
    end

    // Transmitter: flag clears come first so a completing frame wins over a STAT read.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = tx_done_q;
        tx_line_d  = 1'b1;
        if (rd_stat)
            tx_done_d = 1'b0;
        if (wr_txd && !tx_busy_q) begin
            tx_data_d = wdata[7:0];
            tx_busy_d = 1'b1;
        end
        case (tx_state_q)
            S_IDLE: begin
                if (tx_busy_q && tick) begin
                    tx_state_d = S_START;
                    tx_tcnt_d  = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        tx_state_d = S_DATA;
                        tx_bit_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        if (tx_bit_q == 3'd7)
                            tx_state_d = S_STOP;
                        else
                            tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        tx_state_d = S_IDLE;
                        tx_busy_d  = 1'b0;
                        tx_done_d  = 1'b1;
                    end
                end
            end
        endcase
        // The line is registered from the next state so it never glitches.
        case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_data_q[tx_bit_d];
            default: tx_line_d = 1'b1;
        endcase
    end

    // Receiver: sample mid-bit, 8 ticks after the start edge and every 16 thereafter.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_over_d   = rx_over_q;
        frame_err_d = frame_err_q;
        rx_armed_d  = rx_armed_q;
        if (rd_rxd)
            rx_valid_d = 1'b0;
        if (rd_stat) begin
            rx_over_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        case (rx_state_q)
            S_IDLE: begin
                if (rx_s_q)
                    rx_armed_d = 1'b1;
                if (tick && rx_armed_q && !rx_s_q) begin
                    rx_state_d = S_START;
                    rx_tcnt_d  = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d = 4'd0;
                        rx_bit_d  = 3'd0;
                        rx_state_d = rx_s_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7)
                            rx_state_d = S_STOP;
                        else
                            rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_state_d = S_IDLE;
                        rx_armed_d = 1'b0;
                        if (rx_s_q) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                            if (rx_valid_q && !rd_rxd)
                                rx_over_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q  <= '0;
            tx_state_q  <= S_IDLE;
            tx_tcnt_q   <= 4'd0;
            tx_bit_q    <= 3'd0;
            tx_data_q   <= 8'd0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_line_q   <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_tcnt_q   <= 4'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_over_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_armed_q  <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
            tx_line_q   <= tx_line_d;
            rx_meta_q   <= uart_rx;
            rx_s_q      <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_over_q   <= rx_over_d;
            frame_err_q <= frame_err_d;
            rx_armed_q  <= rx_armed_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            irq_q       <= irq_d;
        end
    end

    assign uart_tx = tx_line_q;
    assign irq     = irq_q;
endmodule
